first_stage_quadrant_top: RTL and testbench

- Address generator for the first convolution stage.
- Walks every K×K window of one 32×32 quadrant of a 64×64 input image, for every filter, and emits one filter-weight address and one input-pixel address per enabled cycle.
- Sits between the stage controller (which supplies en and quadrant) and the weight/input memories (which consume the addresses).

---
 rtl/first_stage_quadrant_top_pkg.sv | 35 +++
 rtl/first_stage_quadrant_top_if.sv | 22 ++
 rtl/first_stage_quadrant_top_conv_window_counter.sv | 50 +++++
 rtl/first_stage_quadrant_top.sv | 70 +++++++
 tb/tb_first_stage_quadrant_top.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/first_stage_quadrant_top_pkg.sv
// first_stage_quadrant_top_pkg: shared constants, quadrant codes, FSM states and address helpers
package first_stage_quadrant_top_pkg;

    localparam int IMG_W       = 64;
    localparam int Q_W         = IMG_W / 2;
    localparam int K           = 3;
    localparam int STRIDE      = 1;
    localparam int NUM_FILTERS = 4;
    localparam int NOUT        = (Q_W - K) / STRIDE + 1;

    localparam logic [1:0] QUAD_TL = 2'b00;
    localparam logic [1:0] QUAD_TR = 2'b01;
    localparam logic [1:0] QUAD_BL = 2'b10;
    localparam logic [1:0] QUAD_BR = 2'b11;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Weight memory holds filters back to back, each as a row-major K x K block
    function automatic logic [7:0] weight_addr(logic [7:0] f, logic [7:0] kr, logic [7:0] kc);
        int a;
        a = int'(f) * K * K + int'(kr) * K + int'(kc);
        return 8'(a);
    endfunction

    // Pixel address of one kernel tap inside the selected quadrant
    function automatic logic [11:0] pixel_addr(logic [1:0] q, logic [7:0] orow, logic [7:0] ocol,
                                               logic [7:0] kr, logic [7:0] kc);
        int row;
        int col;
        row = (q[1] ? Q_W : 0) + int'(orow) * STRIDE + int'(kr);
        col = (q[0] ? Q_W : 0) + int'(ocol) * STRIDE + int'(kc);
        return 12'(row * IMG_W + col);
    endfunction

endpackage

// File: rtl/first_stage_quadrant_top_if.sv
// first_stage_quadrant_top_if: controller-side enable/quadrant and memory-side address bus
interface first_stage_quadrant_top_if;

    logic        en;
    logic [1:0]  quadrant;
    logic [7:0]  filter_address;
    logic        filter_address_ready;
    logic [11:0] input_address;
    logic        input_address_ready;
    logic        done;

    modport master (
        output en, quadrant,
        input  filter_address, filter_address_ready, input_address, input_address_ready, done
    );

    modport slave (
        input  en, quadrant,
        output filter_address, filter_address_ready, input_address, input_address_ready, done
    );

endinterface

// File: rtl/first_stage_quadrant_top_conv_window_counter.sv
// conv_window_counter: nested filter/out-row/out-col/kernel-row/kernel-col counter with step enable
module conv_window_counter
    import first_stage_quadrant_top_pkg::*;
(
    input  logic       clock,
    input  logic       clear_n,
    input  logic       step,
    output logic [7:0] f,
    output logic [7:0] orow,
    output logic [7:0] ocol,
    output logic [7:0] kr,
    output logic [7:0] kc,
    output logic       last
);

    logic kc_end;
    logic kr_end;
    logic ocol_end;
    logic orow_end;
    logic f_end;

    assign kc_end   = kc == 8'(K - 1);
    assign kr_end   = kr == 8'(K - 1);
    assign ocol_end = ocol == 8'(NOUT - 1);
    assign orow_end = orow == 8'(NOUT - 1);
    assign f_end    = f == 8'(NUM_FILTERS - 1);
    assign last     = kc_end && kr_end && ocol_end && orow_end && f_end;

    // Each level advances only when every inner level wraps on this step
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            f    <= '0;
            orow <= '0;
            ocol <= '0;
            kr   <= '0;
            kc   <= '0;
        end else if (step) begin
            kc <= kc_end ? 8'd0 : kc + 8'd1;
            if (kc_end)
                kr <= kr_end ? 8'd0 : kr + 8'd1;
            if (kc_end && kr_end)
                ocol <= ocol_end ? 8'd0 : ocol + 8'd1;
            if (kc_end && kr_end && ocol_end)
                orow <= orow_end ? 8'd0 : orow + 8'd1;
            if (kc_end && kr_end && ocol_end && orow_end)
                f <= f_end ? 8'd0 : f + 8'd1;
        end
    end

endmodule

// File: rtl/first_stage_quadrant_top.sv
// first_stage_quadrant_top: weight/pixel address generator scanning all KxK windows of one quadrant
module first_stage_quadrant_top
    import first_stage_quadrant_top_pkg::*;
(
    input  logic                        clock,
    input  logic                        clear_n,
    first_stage_quadrant_top_if.slave   bus
);

    state_t      state;
    logic [1:0]  quad;
    logic [1:0]  quad_eff;
    logic        step;
    logic        last;
    logic        ready;
    logic        done;
    logic [7:0]  filter_address;
    logic [11:0] input_address;
    logic [7:0]  f;
    logic [7:0]  orow;
    logic [7:0]  ocol;
    logic [7:0]  kr;
    logic [7:0]  kc;

    // The first pair is produced on the same edge that leaves IDLE, so it must use the live quadrant
    assign step     = bus.en && state != DONE;
    assign quad_eff = state == IDLE ? bus.quadrant : quad;

    conv_window_counter u_counter (
        .clock   (clock),
        .clear_n (clear_n),
        .step    (step),
        .f       (f),
        .orow    (orow),
        .ocol    (ocol),
        .kr      (kr),
        .kc      (kc),
        .last    (last)
    );

    // FSM, quadrant latch and registered address outputs
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state          <= IDLE;
            quad           <= QUAD_TL;
            ready          <= 1'b0;
            done           <= 1'b0;
            filter_address <= '0;
            input_address  <= '0;
        end else begin
            ready <= step;
            if (state == IDLE)
                quad <= bus.quadrant;
            if (state == DONE)
                done <= 1'b1;
            if (step) begin
                filter_address <= weight_addr(f, kr, kc);
                input_address  <= pixel_addr(quad_eff, orow, ocol, kr, kc);
                state          <= last ? DONE : RUN;
            end
        end
    end

    assign bus.filter_address       = filter_address;
    assign bus.filter_address_ready = ready;
    assign bus.input_address        = input_address;
    assign bus.input_address_ready  = ready;
    assign bus.done                 = done;

endmodule

// File: tb/tb_first_stage_quadrant_top.sv
// tb_first_stage_quadrant_top: directed stimulus, per-cycle model compare and literal checkpoints
module tb_first_stage_quadrant_top;

    localparam int TOTAL = 4 * 30 * 30 * 9;

    logic clock = 1'b0;
    logic clear_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    first_stage_quadrant_top_if bus ();

    first_stage_quadrant_top dut (
        .clock   (clock),
        .clear_n (clear_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    // Reference: pair number n of a scan decoded by plain division into loop indices
    function automatic int exp_faddr(int n);
        int f;
        int kr;
        int kc;
        kc = n % 3;
        kr = (n / 3) % 3;
        f  = n / (9 * 30 * 30);
        return f * 9 + kr * 3 + kc;
    endfunction

    function automatic int exp_iaddr(int n, logic [1:0] q);
        int kc;
        int kr;
        int ocol;
        int orow;
        kc   = n % 3;
        kr   = (n / 3) % 3;
        ocol = (n / 9) % 30;
        orow = (n / 270) % 30;
        return ((q[1] ? 32 : 0) + orow + kr) * 64 + (q[0] ? 32 : 0) + ocol + kc;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: counts pairs emitted and what the outputs must read after each edge
    logic       m_started;
    logic [1:0] m_q;
    int         m_n;
    logic       m_ready;
    logic       m_done;
    int         m_fa;
    int         m_ia;

    always @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            m_started = 1'b0;
            m_q = 2'b00;
            m_n = 0;
            m_ready = 1'b0;
            m_done = 1'b0;
            m_fa = 0;
            m_ia = 0;
        end else if (m_n == TOTAL) begin
            m_ready = 1'b0;
            m_done = 1'b1;
        end else begin
            if (!m_started)
                m_q = bus.quadrant;
            m_ready = bus.en;
            if (bus.en) begin
                m_started = 1'b1;
                m_fa = exp_faddr(m_n);
                m_ia = exp_iaddr(m_n, m_q);
                m_n++;
            end
        end
    end

    // Compare every cycle, away from the active edge
    always @(negedge clock) begin
        chk("filter_address", int'(bus.filter_address), m_fa);
        chk("input_address", int'(bus.input_address), m_ia);
        chk("filter_ready", int'(bus.filter_address_ready), int'(m_ready));
        chk("input_ready", int'(bus.input_address_ready), int'(m_ready));
        chk("done", int'(bus.done), int'(m_done));
    end

    task automatic check_zero(input string name);
        chk({name, "_fa"}, int'(bus.filter_address), 0);
        chk({name, "_ia"}, int'(bus.input_address), 0);
        chk({name, "_rdy"}, int'(bus.input_address_ready), 0);
        chk({name, "_done"}, int'(bus.done), 0);
    endtask

    // Asynchronous reset between edges, then start a new scan on quadrant q
    task automatic restart(input logic [1:0] q, input int first_ia);
        @(negedge clock);
        #2 clear_n = 1'b0;
        #1 check_zero("async_reset");
        @(negedge clock);
        clear_n = 1'b1;
        bus.quadrant = q;
        bus.en = 1'b1;
        @(negedge clock);
        chk("restart_first_ia", int'(bus.input_address), first_ia);
        chk("restart_first_fa", int'(bus.filter_address), 0);
        chk("restart_first_rdy", int'(bus.input_address_ready), 1);
    endtask

    int first_ia [10] = '{'h800, 'h801, 'h802, 'h840, 'h841, 'h842, 'h880, 'h881, 'h882, 'h801};
    int first_fa [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 0};

    initial begin
        int pairs;
        int budget;
        int last_ia;
        int last_fa;
        bus.en = 1'b0;
        bus.quadrant = 2'b00;
        chk("model_pin_q10_n0", exp_iaddr(0, 2'b10), 'h800);
        chk("model_pin_q11_n0", exp_iaddr(0, 2'b11), 'h820);
        chk("model_pin_last_f0", exp_iaddr(8099, 2'b10), 'hFDF);
        chk("model_pin_last_fa", exp_faddr(TOTAL - 1), 'h23);
        repeat (2) @(negedge clock);
        clear_n = 1'b1;
        repeat (10) @(negedge clock);
        check_zero("idle");
        bus.quadrant = 2'b10;
        bus.en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk($sformatf("seq_ia_%0d", i), int'(bus.input_address), first_ia[i]);
            chk($sformatf("seq_fa_%0d", i), int'(bus.filter_address), first_fa[i]);
            chk($sformatf("seq_rdy_%0d", i), int'(bus.filter_address_ready), 1);
            if (i == 4)
                bus.quadrant = 2'b01;
        end
        bus.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("pause_rdy", int'(bus.input_address_ready), 0);
            chk("pause_ia_hold", int'(bus.input_address), 'h801);
        end
        bus.en = 1'b1;
        @(negedge clock);
        chk("resume_ia", int'(bus.input_address), 'h802);
        chk("resume_fa", int'(bus.filter_address), 1);
        repeat (20) @(negedge clock);
        restart(2'b11, 'h820);
        repeat (15) @(negedge clock);
        restart(2'b00, 'h000);
        repeat (15) @(negedge clock);
        restart(2'b10, 'h800);
        pairs = 1;
        budget = 0;
        last_ia = 0;
        last_fa = 0;
        while (!bus.done && budget < 40000) begin
            if (budget == 500) bus.en = 1'b0;
            if (budget == 503) bus.en = 1'b1;
            @(negedge clock);
            budget++;
            if (bus.input_address_ready) begin
                pairs++;
                last_ia = int'(bus.input_address);
                last_fa = int'(bus.filter_address);
                if (pairs == 8100) begin
                    chk("filter0_last_ia", last_ia, 'hFDF);
                    chk("filter0_last_fa", last_fa, 'h08);
                end
            end
        end
        chk("scan_finished_in_budget", int'(bus.done), 1);
        chk("scan_pair_count", pairs, TOTAL);
        chk("scan_last_ia", last_ia, 'hFDF);
        chk("scan_last_fa", last_fa, 'h23);
        repeat (5) begin
            @(negedge clock);
            chk("done_sticky", int'(bus.done), 1);
            chk("done_rdy_low", int'(bus.input_address_ready), 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
